// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter; partial stores become a read-modify-write through MERGE_WR.
// Define DMEM_ARB_RR_EN for round-robin arbitration; default is fixed priority with requester 0 winning.
module dmem_arbiter #(
    parameter int MEM_SIZE = 2000
) (
    input  logic        clk,
    input  logic        rst_n,
    // requester 0: pipeline MEM stage
    input  logic        c_req,
    input  logic        c_we,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    input  logic [3:0]  c_be,
    output logic        c_gnt,
    output logic        c_rvalid,
    output logic [31:0] c_rdata,
    output logic        c_err,
    // requester 1: debug/loader
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    // memory
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);
    localparam logic [29:0] MEM_WORDS = 30'(MEM_SIZE);

    typedef enum logic {IDLE, MERGE_WR} state_t;

    state_t      state_q, state_d;
    logic        c_rvalid_q, c_rvalid_d, d_rvalid_q, d_rvalid_d;
    logic        c_err_q, c_err_d, d_err_q, d_err_d;
    logic [31:0] c_rdata_q, c_rdata_d, d_rdata_q, d_rdata_d;
    logic [31:0] m_addr_q, m_addr_d, m_wdata_q, m_wdata_d, m_old_q, m_old_d;
    logic [3:0]  m_be_q, m_be_d;

    logic        pick_d;
    logic        g_we;
    logic [31:0] g_addr, g_wdata;
    logic [3:0]  g_be;
    logic        in_range;
    logic        mem_we_raw;
    logic [31:0] be_mask;

`ifdef DMEM_ARB_RR_EN
    logic ptr_q, ptr_d;  // 1: requester 1 wins the next contention
    assign pick_d = d_req && (!c_req || ptr_q);
`else
    assign pick_d = d_req && !c_req;
`endif

    always_comb begin
        g_we    = pick_d ? d_we    : c_we;
        g_addr  = pick_d ? d_addr  : c_addr;
        g_wdata = pick_d ? d_wdata : c_wdata;
        g_be    = pick_d ? d_be    : c_be;
    end

    assign in_range = (g_addr[31:2] < MEM_WORDS);
    assign be_mask  = {{8{m_be_q[3]}}, {8{m_be_q[2]}}, {8{m_be_q[1]}}, {8{m_be_q[0]}}};

    always_comb begin
        state_d    = state_q;
        c_gnt      = 1'b0;
        d_gnt      = 1'b0;
        c_rvalid_d = 1'b0;
        d_rvalid_d = 1'b0;
        c_err_d    = 1'b0;
        d_err_d    = 1'b0;
        c_rdata_d  = c_rdata_q;
        d_rdata_d  = d_rdata_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        m_old_d    = m_old_q;
        m_be_d     = m_be_q;
        mem_we_raw = 1'b0;
        mem_addr   = g_addr;
        mem_wdata  = g_wdata;
`ifdef DMEM_ARB_RR_EN
        ptr_d      = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (rst_n && (c_req || d_req)) begin
                    c_gnt = !pick_d;
                    d_gnt = pick_d;
`ifdef DMEM_ARB_RR_EN
                    ptr_d = !pick_d;
`endif
                    c_rvalid_d = c_gnt && !g_we;
                    d_rvalid_d = d_gnt && !g_we;
                    c_err_d    = c_gnt && !in_range;
                    d_err_d    = d_gnt && !in_range;
                    if (c_gnt && !g_we) c_rdata_d = in_range ? mem_rdata : 32'h0;
                    if (d_gnt && !g_we) d_rdata_d = in_range ? mem_rdata : 32'h0;
                    if (g_we && in_range) begin
                        if (g_be == 4'b1111) begin
                            mem_we_raw = 1'b1;
                        end else if (g_be != 4'b0000) begin
                            // capture the old word now; the merged store goes out next cycle
                            m_addr_d  = g_addr;
                            m_wdata_d = g_wdata;
                            m_be_d    = g_be;
                            m_old_d   = mem_rdata;
                            state_d   = MERGE_WR;
                        end
                    end
                end
            end
            MERGE_WR: begin
                mem_we_raw = 1'b1;
                mem_addr   = m_addr_q;
                mem_wdata  = (m_old_q & ~be_mask) | (m_wdata_q & be_mask);
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // a reset landing in MERGE_WR must never let the merged store out
    assign mem_we = rst_n && mem_we_raw;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            c_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            c_err_q    <= 1'b0;
            d_err_q    <= 1'b0;
            c_rdata_q  <= 32'h0;
            d_rdata_q  <= 32'h0;
            m_addr_q   <= 32'h0;
            m_wdata_q  <= 32'h0;
            m_old_q    <= 32'h0;
            m_be_q     <= 4'h0;
`ifdef DMEM_ARB_RR_EN
            ptr_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            c_rvalid_q <= c_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
            c_err_q    <= c_err_d;
            d_err_q    <= d_err_d;
            c_rdata_q  <= c_rdata_d;
            d_rdata_q  <= d_rdata_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            m_old_q    <= m_old_d;
            m_be_q     <= m_be_d;
`ifdef DMEM_ARB_RR_EN
            ptr_q      <= ptr_d;
`endif
        end
    end

    assign c_rvalid = c_rvalid_q;
    assign d_rvalid = d_rvalid_q;
    assign c_err    = c_err_q;
    assign d_err    = d_err_q;
    assign c_rdata  = c_rdata_q;
    assign d_rdata  = d_rdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then random traffic against a transaction-level
// model of the two requesters, the arbitration rule and the memory contents.
module tb_dmem_arbiter;
    localparam int MEM_SIZE = 2000;
    localparam int NPRE     = 40;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        c_req, c_we, c_gnt, c_rvalid, c_err;
    logic [31:0] c_addr, c_wdata, c_rdata;
    logic [3:0]  c_be;
    logic        d_req, d_we, d_gnt, d_rvalid, d_err;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;

    // backing memory; backdoor port used only for preload
    logic [31:0] mem [MEM_SIZE];
    logic        bd_we;
    int          bd_idx;
    logic [31:0] bd_data;

    int checks = 0;
    int errors = 0;

    // model state
    logic [31:0] ref_mem [MEM_SIZE];
    txn_t        qc[$], qd[$];
    int          gseq[$];
    bit          mg_pend;
    txn_t        mg;
    int          last_g;
    bit          e_rv[2], e_err[2];
    logic [31:0] e_rd[2];

    // last sampled DUT values for directed checks
    logic        o_rv[2], o_err[2], o_cg, o_dg, o_we;
    logic [31:0] o_rd[2], o_wd;

    always #5 clk = ~clk;

    dmem_arbiter #(.MEM_SIZE(MEM_SIZE)) dut (
        .clk(clk), .rst_n(rst_n),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_be(c_be),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_err(c_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    assign mem_rdata = ({2'b00, mem_addr[31:2]} < MEM_SIZE) ? mem[mem_addr[31:2]] : 32'hBAD0_BAD0;

    always @(posedge clk) begin
        if (bd_we) mem[bd_idx] <= bd_data;
        else if (mem_we && ({2'b00, mem_addr[31:2]} < MEM_SIZE)) mem[mem_addr[31:2]] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic txn_t gen();
        txn_t t;
        int   r = $urandom_range(0, 19);
        int   w = (r == 0) ? MEM_SIZE + $urandom_range(0, 3) : $urandom_range(0, 31);
        t.we    = 1'($urandom_range(0, 1));
        t.addr  = (r == 1) ? ($urandom | 32'h8000_0000) : ((w << 2) | $urandom_range(0, 3));
        t.wdata = $urandom;
        case ($urandom_range(0, 3))
            0:       t.be = 4'b1111;
            1:       t.be = 4'b0000;
            default: t.be = 4'($urandom_range(0, 15));
        endcase
        return t;
    endfunction

    task automatic drive();
        c_req = (qc.size() != 0);
        d_req = (qd.size() != 0);
        if (c_req) {c_we, c_addr, c_wdata, c_be} = qc[0];
        if (d_req) {d_we, d_addr, d_wdata, d_be} = qd[0];
    endtask

    // one clock: check last cycle's responses and this cycle's grant/memory traffic
    task automatic step();
        txn_t        t;
        int          who, idx;
        bit          inr, eg_c, eg_d, ew;
        logic [31:0] ewa, ewd;
        drive();
        #1;
        o_rv[0] = c_rvalid; o_rv[1] = d_rvalid; o_err[0] = c_err; o_err[1] = d_err;
        o_rd[0] = c_rdata;  o_rd[1] = d_rdata;  o_cg = c_gnt; o_dg = d_gnt;
        o_we = mem_we; o_wd = mem_wdata;
        chk("c_rvalid", c_rvalid, e_rv[0]);
        chk("d_rvalid", d_rvalid, e_rv[1]);
        chk("c_err", c_err, e_err[0]);
        chk("d_err", d_err, e_err[1]);
        if (e_rv[0]) chk("c_rdata", c_rdata, e_rd[0]);
        if (e_rv[1]) chk("d_rdata", d_rdata, e_rd[1]);
        if (c_gnt || d_gnt) gseq.push_back(d_gnt ? 1 : 0);
        for (int i = 0; i < 2; i++) begin e_rv[i] = 0; e_err[i] = 0; end
        eg_c = 0; eg_d = 0; ew = 0; ewa = 0; ewd = 0;
        if (mg_pend) begin
            idx = int'({2'b00, mg.addr[31:2]});
            ew = 1; ewa = mg.addr;
            ewd = merge(ref_mem[idx], mg.wdata, mg.be);
            ref_mem[idx] = ewd;
            mg_pend = 0;
        end else if (qc.size() != 0 || qd.size() != 0) begin
            if (qc.size() == 0) who = 1;
            else if (qd.size() == 0) who = 0;
            else begin
`ifdef DMEM_ARB_RR_EN
                who = (last_g == 0) ? 1 : 0;
`else
                who = 0;
`endif
            end
            t = who ? qd.pop_front() : qc.pop_front();
            last_g = who;
            eg_c = (who == 0); eg_d = (who == 1);
            idx = int'({2'b00, t.addr[31:2]});
            inr = ({2'b00, t.addr[31:2]} < MEM_SIZE);
            e_err[who] = !inr;
            if (!t.we) begin
                e_rv[who] = 1;
                e_rd[who] = inr ? ref_mem[idx] : 32'h0;
            end else if (inr && t.be == 4'b1111) begin
                ew = 1; ewa = t.addr; ewd = t.wdata;
                ref_mem[idx] = t.wdata;
            end else if (inr && t.be != 4'b0000) begin
                mg_pend = 1; mg = t;
            end
        end
        chk("c_gnt", c_gnt, eg_c);
        chk("d_gnt", d_gnt, eg_d);
        chk("mem_we", mem_we, ew);
        if (ew) begin
            chk("mem_word", {2'b00, mem_addr[31:2]}, {2'b00, ewa[31:2]});
            chk("mem_wdata", mem_wdata, ewd);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        c_req = 0; d_req = 0; rst_n = 0;
        #1;
        chk("rst_comb_we", mem_we, 0);
        chk("rst_comb_cgnt", c_gnt, 0);
        chk("rst_comb_dgnt", d_gnt, 0);
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_c_rvalid", c_rvalid, 0);
        chk("rst_d_rvalid", d_rvalid, 0);
        chk("rst_c_err", c_err, 0);
        chk("rst_d_err", d_err, 0);
        chk("rst_c_rdata", c_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_mem_we", mem_we, 0);
        rst_n = 1;
        #1;
        chk("rst_idle_we", mem_we, 0);
        qc.delete(); qd.delete();
        mg_pend = 0; last_g = 1;
        for (int i = 0; i < 2; i++) begin e_rv[i] = 0; e_err[i] = 0; e_rd[i] = 0; end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] old12;
        logic [3:0]  seq;
        int          mism;
        rst_n = 0; c_req = 0; d_req = 0; bd_we = 0; bd_idx = 0; bd_data = 0;
        {c_we, c_addr, c_wdata, c_be} = '0;
        {d_we, d_addr, d_wdata, d_be} = '0;
        for (int i = 0; i < MEM_SIZE; i++) ref_mem[i] = 32'h0;
        @(negedge clk);
        for (int i = 0; i < NPRE; i++) begin
            bd_idx  = i;
            bd_data = (i == 4) ? 32'hDEADBEEF : (i == 8) ? 32'h11223344 : $urandom;
            ref_mem[i] = bd_data;
            bd_we = 1;
            @(posedge clk);
            @(negedge clk);
        end
        bd_we = 0;
        do_reset(2);

        // read of word 4
        qc.push_back('{we: 1'b0, addr: 32'h10, wdata: 32'h0, be: 4'hF});
        step();
        chk("r24_gnt", o_cg, 1);
        step();
        chk("r24_rvalid", o_rv[0], 1);
        chk("r24_rdata", o_rd[0], 32'hDEADBEEF);

        // partial write merge into word 8, with a d read waiting
        qc.push_back('{we: 1'b1, addr: 32'h20, wdata: 32'h0000AA00, be: 4'b0010});
        step();
        chk("r25_gnt", o_cg, 1);
        chk("r25_gnt_we", o_we, 0);
        qd.push_back('{we: 1'b0, addr: 32'h4, wdata: 32'h0, be: 4'hF});
        step();
        chk("r25_merge_we", o_we, 1);
        chk("r25_merge_wd", o_wd, 32'h1122AA44);
        chk("r25_no_cgnt", o_cg, 0);
        chk("r25_no_dgnt", o_dg, 0);
        step();
        chk("r25_d_after", o_dg, 1);
        step();

        // contention: two reads each
        gseq.delete();
        qc.push_back('{we: 1'b0, addr: 32'h0, wdata: 32'h0, be: 4'hF});
        qc.push_back('{we: 1'b0, addr: 32'h4, wdata: 32'h0, be: 4'hF});
        qd.push_back('{we: 1'b0, addr: 32'h8, wdata: 32'h0, be: 4'hF});
        qd.push_back('{we: 1'b0, addr: 32'hC, wdata: 32'h0, be: 4'hF});
        repeat (4) step();
        step();
        chk("r26_ngrants", gseq.size(), 4);
        seq = 4'b0;
        for (int i = 0; i < gseq.size() && i < 4; i++) seq = {seq[2:0], gseq[i] == 1};
`ifdef DMEM_ARB_RR_EN
        chk("r26_order", seq, 4'b0101);
`else
        chk("r26_order", seq, 4'b0011);
`endif

        // out-of-range full write
        qd.push_back('{we: 1'b1, addr: 32'h1F40, wdata: 32'h12345678, be: 4'hF});
        step();
        chk("r27_gnt", o_dg, 1);
        chk("r27_we", o_we, 0);
        step();
        chk("r27_err", o_err[1], 1);
        chk("r27_c_err", o_err[0], 0);

        // be=0000 write, then a read granted right after
        qc.push_back('{we: 1'b1, addr: 32'h0, wdata: 32'hFFFFFFFF, be: 4'h0});
        qc.push_back('{we: 1'b0, addr: 32'h0, wdata: 32'h0, be: 4'hF});
        step();
        chk("r29_gnt", o_cg, 1);
        chk("r29_we", o_we, 0);
        step();
        chk("r29_next_gnt", o_cg, 1);
        step();

        // reset while the merge is pending
        old12 = ref_mem[12];
        qc.push_back('{we: 1'b1, addr: 32'h30, wdata: 32'hCAFEF00D, be: 4'b1001});
        step();
        chk("r28_gnt", o_cg, 1);
        do_reset(1);
        chk("r28_mem", mem[12], old12);
        qc.push_back('{we: 1'b0, addr: 32'h30, wdata: 32'h0, be: 4'hF});
        step();
        chk("r28_idle_gnt", o_cg, 1);
        step();

        // random traffic
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 299) == 0) do_reset(1);
            else begin
                if (qc.size() == 0 && $urandom_range(0, 3) != 0) qc.push_back(gen());
                if (qd.size() == 0 && $urandom_range(0, 3) != 0) qd.push_back(gen());
                step();
            end
        end
        for (int n = 0; n < 20 && (qc.size() != 0 || qd.size() != 0 || mg_pend); n++) step();
        step();

        mism = 0;
        for (int i = 0; i < NPRE; i++) if (mem[i] !== ref_mem[i]) mism++;
        chk("mem_final", mism, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
